alu_pipe_hs: RTL and testbench
==============================

Name: alu_pipe_hs

Overview:
- Parametrised successor to the fixed 32-bit, 3-stage CPU ALU.
- Adds generic WIDTH, valid/ready handshakes on both sides with full backpressure, an iterative multi-cycle signed divider that stalls the pipe, and an illegal-opcode error flag.
- Sits between the register-file read stage and the Z (hi/lo) result registers of the datapath.

Parameters:
- WIDTH, 32, operand width in bits; power of two, 8 to 64.
- SHW, $clog2(WIDTH), number of B bits used as the shift/rotate amount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode beat is valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B (shift amount, or sole operand for NEG/NOT).
- opcode  in  5  operation code.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  2*WIDTH  {hi, lo}.
- out_err  out  1  illegal opcode on this beat.
- flags  out  4  {N, Z, C, V}; see Optional Feature.

Behaviour:
- Reset: clear_n low asynchronously empties all stages. out_valid=0, result=0, out_err=0, flags=0, divider idle. in_ready=1 from the first edge after release.
- Opcodes (unchanged encoding):
  - ADD 00011, SUB 00100, AND 00101, OR 00110.
  - ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011.
  - DIV 01111, MUL 10000, NEG 10001, NOT 10010.
  - Any other code: result=0, out_err=1.
- Result width rules:
  - All ops except MUL/DIV: hi=0, lo=WIDTH-bit result.
  - MUL: signed A*B, full 2*WIDTH product.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder carrying the sign of A.
  - DIV by zero: lo=all ones, hi=A, out_err=1.
  - DIV of most-negative by -1: lo=A, hi=0, no error.
- Shifts/rotates use b_in[SHW-1:0] only. SHRA replicates A[WIDTH-1]. NEG/NOT operate on B.
- Pipeline stages:
  - S1 latches the operand beat when in_valid && in_ready.
  - S2 executes.
  - S3 is the output register.
- Stall rules:
  - stall3 = out_valid && !out_ready.
  - S2 holds if stall3, or if the divider is busy or its result is not yet written.
  - S1 holds if S2 holds.
  - in_ready = !(S1 full && S1 holding).
  - Stages advance independently, so bubbles collapse.
- Latency: non-DIV ops reach out_valid 3 cycles after acceptance with out_ready=1. Throughput is 1 beat/cycle.
- Divider FSM: IDLE -> CALC -> DONE -> IDLE.
  - IDLE -> CALC when a DIV beat sits in S2: capture |A|, |B| and signs; set count=WIDTH.
  - Divide-by-zero goes IDLE -> DONE directly (1 cycle).
  - CALC: one restoring-division step per cycle; count decrements; at count==0 -> DONE.
  - DONE: apply signs and present the result to S3. Leave to IDLE only when S3 accepts.
  - DIV latency is 3+WIDTH+1 cycles. Beats behind it stall, so result order always equals issue order.
- Backpressure:
  - While out_valid=1 && out_ready=0, result, out_err and flags hold stable.
  - No beat is dropped or duplicated.
- clear_n assertion mid-DIV aborts the FSM to IDLE and discards all in-flight beats.

Optional Feature:
- Macro ALU_PIPE_FLAGS_EN.
- When defined, flags are registered in S3 alongside result:
  - N = result MSB of the valid width (bit 2*WIDTH-1 for MUL/DIV, bit WIDTH-1 otherwise).
  - Z = that result equals 0.
  - C = carry out for ADD, borrow-not for SUB, 0 otherwise.
  - V = signed overflow for ADD/SUB/NEG, 0 otherwise.
- When undefined, flags is tied to 4'b0000 and no flag logic is synthesised.

Test Plan:
- WIDTH=32, out_ready=1; ADD A=0x7FFFFFFF, B=1 -> 3 cycles later lo=0x80000000, hi=0, flags N=1,Z=0,C=0,V=1 (with macro).
- MUL A=0xFFFFFFFE (-2), B=3 -> result=0xFFFFFFFF_FFFFFFFA. Then SHRA A=0x80000000, B=0x24 (amount 4) -> lo=0xF8000000.
- DIV A=-7, B=2, followed by ADD 1+1 next cycle -> DIV result hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3) after 36 cycles; ADD result 2 follows 1 cycle later, in order. in_ready stays 0 once S1 holds the ADD.
- DIV A=5, B=0 -> lo=0xFFFFFFFF, hi=5, out_err=1. Opcode 5'b11111 -> result 0, out_err=1.
- Stream 8 back-to-back ADDs with out_ready toggling 1,0,0,1,...:
  - Every result appears exactly once, in order.
  - Outputs are stable while stalled.
  - in_ready deasserts only when S1 is full and stalled.
- Pull clear_n low during CALC (count=10) -> out_valid=0 immediately. After release, a new ADD 2+3 returns 5 with latency 3.

Source files
------------

// File: rtl/alu_pipe_hs_if.sv
`default_nettype none
// ============================================================================
// alu_pipe_hs_if : operand/result handshake bundle for alu_pipe_hs. Rev 1.0
// ============================================================================
interface alu_pipe_hs_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [4:0]           opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 out_err;
  logic [3:0]           flags;

  modport master (
    output in_valid, a_in, b_in, opcode, out_ready,
    input  in_ready, out_valid, result, out_err, flags
  );

  modport slave (
    input  in_valid, a_in, b_in, opcode, out_ready,
    output in_ready, out_valid, result, out_err, flags
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// alu_pipe_hs : 3-stage valid/ready ALU with iterative signed divider.
// Macro ALU_PIPE_FLAGS_EN adds registered NZCV flags.            Rev 1.0
// ============================================================================
module alu_pipe_hs #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire          clk,
  input  wire          clear_n,
  alu_pipe_hs_if.slave bus
);

  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_ROR  = 5'b00111;
  localparam logic [4:0] c_OP_ROL  = 5'b01000;
  localparam logic [4:0] c_OP_SHR  = 5'b01001;
  localparam logic [4:0] c_OP_SHRA = 5'b01010;
  localparam logic [4:0] c_OP_SHL  = 5'b01011;
  localparam logic [4:0] c_OP_DIV  = 5'b01111;
  localparam logic [4:0] c_OP_MUL  = 5'b10000;
  localparam logic [4:0] c_OP_NEG  = 5'b10001;
  localparam logic [4:0] c_OP_NOT  = 5'b10010;
  localparam int         c_CNT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  logic                 r_live;
  logic                 r_s1_vld, r_s2_vld, r_s3_vld;
  logic [WIDTH-1:0]     r_s1_a, r_s1_b, r_s2_a, r_s2_b;
  logic [4:0]           r_s1_op, r_s2_op;
  logic [2*WIDTH-1:0]   r_s3_res;
  logic                 r_s3_err;

  div_state_t           r_dst, w_dst_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_dq, r_rem, r_dvs;
  logic                 r_neg_q, r_neg_r;

  logic                 w_stall3, w_s2_div, w_s2_hold, w_s2_fire, w_in_ready;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_div_q, w_div_r;
  logic [WIDTH:0]       w_rem_sh, w_diff;
  logic                 w_qbit;
  logic [SHW-1:0]       w_sh;
  logic [2*WIDTH-1:0]   w_mul, w_rol, w_ror;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]     w_lo, w_hi;
  logic                 w_err;

  // A DIV in S2 blocks everything behind it until its result is handed to S3.
  assign w_stall3   = r_s3_vld && !bus.out_ready;
  assign w_s2_div   = r_s2_vld && (r_s2_op == c_OP_DIV);
  assign w_s2_hold  = r_s2_vld && (w_stall3 || (w_s2_div && (r_dst != DIV_DONE)));
  assign w_s2_fire  = r_s2_vld && !w_s2_hold;
  assign w_in_ready = r_live && !(r_s1_vld && w_s2_hold);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_live   <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_op  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_a   <= '0;
      r_s2_b   <= '0;
      r_s2_op  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_in_ready) begin
        r_s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_a  <= bus.a_in;
          r_s1_b  <= bus.b_in;
          r_s1_op <= bus.opcode;
        end
      end
      if (!w_s2_hold) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_a  <= r_s1_a;
          r_s2_b  <= r_s1_b;
          r_s2_op <= r_s1_op;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_dst <= DIV_IDLE;
    else          r_dst <= w_dst_nxt;
  end

  always_comb begin
    w_dst_nxt = r_dst;
    unique case (r_dst)
      DIV_IDLE: if (w_s2_div) w_dst_nxt = (r_s2_b == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (r_cnt == c_CNT_W'(1)) w_dst_nxt = DIV_DONE;
      DIV_DONE: if (w_s2_fire) w_dst_nxt = DIV_IDLE;
      default:  w_dst_nxt = DIV_IDLE;
    endcase
  end

  // Restoring division on magnitudes; signs are reapplied once the loop ends.
  assign w_a_mag  = r_s2_a[WIDTH-1] ? -r_s2_a : r_s2_a;
  assign w_b_mag  = r_s2_b[WIDTH-1] ? -r_s2_b : r_s2_b;
  assign w_rem_sh = {r_rem, r_dq[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit   = !w_diff[WIDTH];
  assign w_div_q  = r_neg_q ? -r_dq : r_dq;
  assign w_div_r  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt   <= '0;
      r_dq    <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_dst == DIV_IDLE) begin
      if (w_s2_div) begin
        r_cnt   <= c_CNT_W'(WIDTH);
        r_dq    <= w_a_mag;
        r_rem   <= '0;
        r_dvs   <= w_b_mag;
        r_neg_q <= r_s2_a[WIDTH-1] ^ r_s2_b[WIDTH-1];
        r_neg_r <= r_s2_a[WIDTH-1];
      end
    end else if (r_dst == DIV_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
      r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    end
  end

  assign w_sh  = r_s2_b[SHW-1:0];
  assign w_mul = $signed({{WIDTH{r_s2_a[WIDTH-1]}}, r_s2_a}) *
                 $signed({{WIDTH{r_s2_b[WIDTH-1]}}, r_s2_b});
  assign w_rol = {r_s2_a, r_s2_a} << w_sh;
  assign w_ror = {r_s2_a, r_s2_a} >> w_sh;
  assign w_sra = $signed(r_s2_a) >>> w_sh;

  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_err = 1'b0;
    case (r_s2_op)
      c_OP_ADD:  w_lo = r_s2_a + r_s2_b;
      c_OP_SUB:  w_lo = r_s2_a - r_s2_b;
      c_OP_AND:  w_lo = r_s2_a & r_s2_b;
      c_OP_OR:   w_lo = r_s2_a | r_s2_b;
      c_OP_ROR:  w_lo = w_ror[WIDTH-1:0];
      c_OP_ROL:  w_lo = w_rol[2*WIDTH-1:WIDTH];
      c_OP_SHR:  w_lo = r_s2_a >> w_sh;
      c_OP_SHRA: w_lo = w_sra;
      c_OP_SHL:  w_lo = r_s2_a << w_sh;
      c_OP_MUL:  {w_hi, w_lo} = w_mul;
      c_OP_NEG:  w_lo = -r_s2_b;
      c_OP_NOT:  w_lo = ~r_s2_b;
      c_OP_DIV: begin
        if (r_s2_b == '0) begin
          w_lo  = '1;
          w_hi  = r_s2_a;
          w_err = 1'b1;
        end else begin
          w_lo = w_div_q;
          w_hi = w_div_r;
        end
      end
      default:   w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_s3_vld <= 1'b0;
      r_s3_res <= '0;
      r_s3_err <= 1'b0;
    end else if (!w_stall3) begin
      r_s3_vld <= w_s2_fire;
      if (w_s2_fire) begin
        r_s3_res <= {w_hi, w_lo};
        r_s3_err <= w_err;
      end
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] r_s3_flg;
  logic       w_fn, w_fz, w_fc, w_fv, w_wide;

  always_comb begin
    w_wide = (r_s2_op == c_OP_MUL) || (r_s2_op == c_OP_DIV);
    w_fn   = w_wide ? w_hi[WIDTH-1] : w_lo[WIDTH-1];
    w_fz   = (w_hi == '0) && (w_lo == '0);
    w_fc   = 1'b0;
    w_fv   = 1'b0;
    // Carry/borrow derived from the W-bit result to avoid a wider adder.
    case (r_s2_op)
      c_OP_ADD: begin
        w_fc = (w_lo < r_s2_a);
        w_fv = (r_s2_a[WIDTH-1] == r_s2_b[WIDTH-1]) && (w_lo[WIDTH-1] != r_s2_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_fc = (r_s2_a >= r_s2_b);
        w_fv = (r_s2_a[WIDTH-1] != r_s2_b[WIDTH-1]) && (w_lo[WIDTH-1] != r_s2_a[WIDTH-1]);
      end
      c_OP_NEG: w_fv = (r_s2_b == {1'b1, {(WIDTH-1){1'b0}}});
      default:  w_fv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                   r_s3_flg <= 4'b0000;
    else if (!w_stall3 && w_s2_fire) r_s3_flg <= {w_fn, w_fz, w_fc, w_fv};
  end

  assign bus.flags = r_s3_flg;
`else
  assign bus.flags = 4'b0000;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s3_vld;
  assign bus.result    = r_s3_res;
  assign bus.out_err   = r_s3_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe_hs : scoreboard bench for alu_pipe_hs (WIDTH=32).      Rev 1.0
// ============================================================================
module tb_alu_pipe_hs;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic [3:0]  flg;
    int          lat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  alu_pipe_hs_if #(.WIDTH(32)) bus ();
  alu_pipe_hs #(.WIDTH(32)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per accepted output beat.
  logic        held = 1'b0;
  logic [63:0] h_res;
  logic        h_err;
  logic [3:0]  h_flg;

  always @(negedge clk) begin : mon
    exp_t       e;
    logic [3:0] ef;
    if (!clear_n) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (held) begin
        chk("hold_res", bus.result, h_res);
        chk("hold_err", 64'(bus.out_err), 64'(h_err));
        chk("hold_flags", 64'(bus.flags), 64'(h_flg));
      end
      if (bus.out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
`ifdef ALU_PIPE_FLAGS_EN
          ef = e.flg;
`else
          ef = 4'b0000;
`endif
          chk("result", bus.result, e.res);
          chk("out_err", 64'(bus.out_err), 64'(e.err));
          chk("flags", 64'(bus.flags), 64'(ef));
          if (e.lat != 0) chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
        end
      end else begin
        held  = 1'b1;
        h_res = bus.result;
        h_err = bus.out_err;
        h_flg = bus.flags;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] er, input logic ee, input logic [3:0] ef,
                      input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a_in     = a;
    bus.b_in     = b;
    n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("accept_timeout", 64'(1), 64'(0));
    e.res = er; e.err = ee; e.flg = ef; e.lat = lat; e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int rdy_low;
    clear_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result", bus.result, 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_flags", 64'(bus.flags), 64'(0));
    clear_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(bus.in_ready), 64'(1));

    // Single-cycle ops, back to back
    send(OP_ADD,  32'h7FFFFFFF, 32'h1,        64'h00000000_80000000, 1'b0, 4'b1001, 3);
    send(OP_MUL,  32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF_FFFFFFFA, 1'b0, 4'b1000, 3);
    send(OP_SHRA, 32'h80000000, 32'h24,       64'h00000000_F8000000, 1'b0, 4'b1000, 3);
    send(OP_SUB,  32'h5,        32'h7,        64'h00000000_FFFFFFFE, 1'b0, 4'b1000, 3);
    send(OP_SUB,  32'h7,        32'h5,        64'h00000000_00000002, 1'b0, 4'b0010, 3);
    send(OP_ADD,  32'hFFFFFFFF, 32'h1,        64'h00000000_00000000, 1'b0, 4'b0110, 3);
    send(OP_AND,  32'h0000F0F0, 32'h0000FF00, 64'h00000000_0000F000, 1'b0, 4'b0000, 3);
    send(OP_OR,   32'h0000F0F0, 32'h0000FF00, 64'h00000000_0000FFF0, 1'b0, 4'b0000, 3);
    send(OP_ROR,  32'h12345678, 32'h8,        64'h00000000_78123456, 1'b0, 4'b0000, 3);
    send(OP_ROL,  32'h12345678, 32'h4,        64'h00000000_23456781, 1'b0, 4'b0000, 3);
    send(OP_SHR,  32'h80000000, 32'h1F,       64'h00000000_00000001, 1'b0, 4'b0000, 3);
    send(OP_SHL,  32'h1,        32'h21,       64'h00000000_00000002, 1'b0, 4'b0000, 3);
    send(OP_NEG,  32'h0,        32'h5,        64'h00000000_FFFFFFFB, 1'b0, 4'b1000, 3);
    send(OP_NEG,  32'h0,        32'h80000000, 64'h00000000_80000000, 1'b0, 4'b1001, 3);
    send(OP_NOT,  32'h0,        32'h0,        64'h00000000_FFFFFFFF, 1'b0, 4'b1000, 3);
    send(5'b11111, 32'h1,       32'h2,        64'h0,                 1'b1, 4'b0100, 3);
    drain();

    // DIV followed immediately by ADD: order kept, ADD stalls behind it
    send(OP_DIV, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 4'b1000, 36);
    send(OP_ADD, 32'h1,        32'h1, 64'h00000000_00000002, 1'b0, 4'b0000, 36);
    rdy_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.in_ready) rdy_low++;
    end
    chk("in_ready_low_during_div", 64'(rdy_low), 64'(20));
    drain();

    // Divider corner cases
    send(OP_DIV, 32'h5,        32'h0,        64'h00000005_FFFFFFFF, 1'b1, 4'b0000, 0);
    drain();
    send(OP_DIV, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 4'b0000, 36);
    send(OP_DIV, 32'h7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 4'b0000, 0);
    send(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 4'b0000, 0);
    drain();

    // Streaming ADDs under a 1,0,0,1 backpressure pattern
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(OP_ADD, 32'(i * 3), 32'h100, 64'(i * 3 + 32'h100), 1'b0, 4'b0000, 0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1 bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Abort a DIV mid-calculation, then restart cleanly
    send(OP_DIV, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 4'b0000, 0);
    repeat (24) @(negedge clk);
    #2 clear_n = 1'b0;
    #1 chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    exp_q.delete();
    @(negedge clk);
    clear_n = 1'b1;
    send(OP_ADD, 32'h2, 32'h3, 64'h00000000_00000005, 1'b0, 4'b0000, 3);
    drain();
    repeat (50) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
